wide_lzc_seq: RTL and testbench

Sequencer that computes the leading-zero count and the normalized (MSB-aligned) value of a wide operand of N_CHUNK*D_WIDTH bits. It time-shares a single D_WIDTH-bit detect_pos_first_one instance, scanning one chunk per cycle from the MSB chunk downward and stopping at the first non-zero chunk. It sits in the fixed-point normalization path ahead of the scaling and exponent logic, with valid/ready handshakes on both sides.

---
 rtl/wide_lzc_pkg.sv | 15 +
 rtl/detect_pos_first_one.sv | 19 +
 rtl/wide_lzc_seq.sv | 115 +++++++++++
 tb/tb_wide_lzc_seq.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/wide_lzc_pkg.sv
// Shared types and width helpers for the chunked leading-zero sequencer.
package wide_lzc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/detect_pos_first_one.sv
// Leading-zero position of the first set bit counted from the MSB; purely combinational.
// An all-zero input also yields 0, so callers must detect zero separately.
module detect_pos_first_one #(
  parameter int D_WIDTH = 16,
  localparam int POS_W  = $clog2(D_WIDTH)
) (
  input  logic [D_WIDTH-1:0] data_i,
  output logic [POS_W-1:0]   pos_o
);

  // Scanning upward lets the highest set bit overwrite any lower ones.
  always_comb begin
    pos_o = '0;
    for (int i = 0; i < D_WIDTH; i++) begin
      if (data_i[i]) pos_o = POS_W'(D_WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/wide_lzc_seq.sv
// Wide LZC + normalize, one chunk per cycle from the MSB; k+2 cycles (N_CHUNK for zero).
// Accepts only in IDLE; result held in DONE until out_ready_i.
module wide_lzc_seq
  import wide_lzc_pkg::*;
#(
  parameter int D_WIDTH  = 16,
  parameter int N_CHUNK  = 4,
  localparam int W_WIDTH = D_WIDTH * N_CHUNK,
  localparam int CNT_W   = cnt_w(W_WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [W_WIDTH-1:0] data_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [CNT_W-1:0]   lzc_o,
  output logic [W_WIDTH-1:0] norm_o,
  output logic               zero_o
);

  localparam int IDX_W = $clog2(N_CHUNK);
  localparam int POS_W = $clog2(D_WIDTH);

  state_t               state_q, state_d;
  logic [W_WIDTH-1:0]   op_q, op_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     lzc_q, lzc_d;
  logic [W_WIDTH-1:0]   norm_q, norm_d;
  logic                 zero_q, zero_d;
  logic [D_WIDTH-1:0]   chunk;
  logic [POS_W-1:0]     pos;

  assign chunk = op_q[int'(idx_q)*D_WIDTH +: D_WIDTH];

  detect_pos_first_one #(
    .D_WIDTH (D_WIDTH)
  ) u_detect (
    .data_i (chunk),
    .pos_o  (pos)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    lzc_d   = lzc_q;
    norm_d  = norm_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          op_d    = data_i;
          idx_d   = IDX_W'(N_CHUNK - 1);
          acc_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (chunk != '0) begin
          lzc_d   = acc_q + CNT_W'(pos);
          state_d = SHIFT;
        end else if (idx_q != '0) begin
          acc_d = acc_q + CNT_W'(D_WIDTH);
          idx_d = idx_q - 1'b1;
        end else begin
          // Every chunk was empty: report full width and skip the shifter.
          lzc_d   = CNT_W'(W_WIDTH);
          norm_d  = '0;
          zero_d  = 1'b1;
          state_d = DONE;
        end
      end
      SHIFT: begin
        norm_d  = op_q << lzc_q;
        zero_d  = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      lzc_q   <= '0;
      norm_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      lzc_q   <= lzc_d;
      norm_q  <= norm_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign lzc_o       = lzc_q;
  assign norm_o      = norm_q;
  assign zero_o      = zero_q;

endmodule

// File: tb/tb_wide_lzc_seq.sv
// Directed and random checks of wide_lzc_seq against a bit-level LZC reference model.
module tb_wide_lzc_seq;
  import wide_lzc_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [63:0] data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [6:0]  lzc_o;
  logic [63:0] norm_o;
  logic        zero_o;

  int tests = 0;
  int fails = 0;
  int shift_cnt = 0;

  wide_lzc_seq #(.D_WIDTH(16), .N_CHUNK(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .data_i      (data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .lzc_o       (lzc_o),
    .norm_o      (norm_o),
    .zero_o      (zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dut.state_q == SHIFT) shift_cnt <= shift_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_lzc(input logic [63:0] d);
    for (int i = 63; i >= 0; i--) begin
      if (d[i]) return 63 - i;
    end
    return 64;
  endfunction

  // Drives one operand through the block and checks latency, results and hold behaviour.
  task automatic run_op(input logic [63:0] d, input int hold);
    int          lz;
    int          exp_lat;
    int          edges;
    int          shift0;
    logic [63:0] exp_norm;
    lz       = ref_lzc(d);
    exp_lat  = (lz == 64) ? 4 : (lz / 16) + 2;
    exp_norm = (lz == 64) ? 64'd0 : (d << lz);
    chk("in_ready_idle", {63'd0, in_ready_o}, 64'd1);
    shift0      = shift_cnt;
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    data_i      = d;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    data_i     = {$urandom, $urandom};
    edges      = 0;
    while (!out_valid_o && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk("latency", 64'(edges), 64'(exp_lat));
    chk("lzc", {57'd0, lzc_o}, 64'(lz));
    chk("norm", norm_o, exp_norm);
    chk("zero", {63'd0, zero_o}, (lz == 64) ? 64'd1 : 64'd0);
    chk("in_ready_busy", {63'd0, in_ready_o}, 64'd0);
    chk("shift_visits", 64'(shift_cnt - shift0), (lz == 64) ? 64'd0 : 64'd1);
    if (hold > 0) begin
      out_ready_i = 1'b0;
      for (int h = 0; h < hold; h++) begin
        in_valid_i = 1'b1;
        data_i     = ~d;
        @(posedge clk);
        #1;
        chk("hold_valid", {63'd0, out_valid_o}, 64'd1);
        chk("hold_ready", {63'd0, in_ready_o}, 64'd0);
        chk("hold_lzc", {57'd0, lzc_o}, 64'(lz));
        chk("hold_norm", norm_o, exp_norm);
      end
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("release_valid", {63'd0, out_valid_o}, 64'd0);
    chk("release_ready", {63'd0, in_ready_o}, 64'd1);
  endtask

  initial begin
    logic [63:0] r;
    int          sh;
    rst         = 1'b1;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    data_i      = '0;
    #1;
    chk("rst_ready", {63'd0, in_ready_o}, 64'd1);
    chk("rst_valid", {63'd0, out_valid_o}, 64'd0);
    chk("rst_lzc", {57'd0, lzc_o}, 64'd0);
    chk("rst_norm", norm_o, 64'd0);
    chk("rst_zero", {63'd0, zero_o}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    run_op(64'h8000_0000_0000_0000, 0);
    run_op(64'h0000_0000_0001_0000, 0);
    run_op(64'h0000_0001_0000_0000, 0);
    run_op(64'h0000_0000_0000_0003, 0);
    run_op(64'h0000_0000_0000_0000, 0);
    run_op(64'h0123_4567_89AB_CDEF, 3);
    run_op(64'h0000_0000_0000_0001, 3);

    // Asynchronous reset in the second SCAN cycle discards the operation.
    in_valid_i = 1'b1;
    data_i     = 64'h0000_0000_0001_0000;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ready", {63'd0, in_ready_o}, 64'd1);
    chk("arst_valid", {63'd0, out_valid_o}, 64'd0);
    chk("arst_lzc", {57'd0, lzc_o}, 64'd0);
    chk("arst_norm", norm_o, 64'd0);
    chk("arst_zero", {63'd0, zero_o}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("arst_no_output", {63'd0, out_valid_o}, 64'd0);
    run_op(64'h0000_0000_0001_0000, 0);

    for (int n = 0; n < 40; n++) begin
      r  = {$urandom, $urandom};
      sh = $urandom_range(0, 64);
      r  = (sh == 64) ? 64'd0 : (r >> sh);
      run_op(r, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
